path_recorder: RTL and testbench
================================

# path_recorder

Initiator-side controller for the move-history stack in the maze game datapath. It accepts player moves and turns each one into a clean push strobe toward the stack. On undo it issues a pop strobe, captures the returned direction code, and emits the inverse move for the motion controller. It keeps its own occupancy count, because the stack exposes no full or empty flags.

## Interface
Parameters:
- DEPTH, 50: stack capacity in entries.
- DW, 2: direction code width.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset. The same rst also drives the stack.
- en  in  1  enables acceptance of new requests.
- move_valid  in  1  a move is offered.
- move_dir  in  DW  offered direction: 00 up, 01 right, 10 down, 11 left.
- move_ready  out  1  move accepted when move_valid and move_ready are both high.
- undo_req  in  1  undo request, sampled only in IDLE.
- undo_valid  out  1  single-cycle pulse carrying the inverse move.
- undo_dir  out  DW  inverse direction; valid while undo_valid is high.
- depth  out  $clog2(DEPTH+1)  current number of stored entries.
- full  out  1  depth == DEPTH.
- empty  out  1  depth == 0.
- rewind_req  in  1  rewind-all request (see Configuration).
- rewind_busy  out  1  a rewind is in progress.
- stk_en  out  1  stack enable. Equals en OR (state != IDLE).
- stk_push  out  1  push strobe.
- stk_push_val  out  DW  value to push.
- stk_pop  out  1  pop strobe.
- stk_pop_val  in  DW  popped value. The stack registers it, so it is valid in the cycle after the stk_pop-high cycle.

## Operation
States:
- IDLE: no strobes. Accept requests in this order of priority:
  - If rewind_req and !empty: enter POP with rewind active.
  - Otherwise, if undo_req and !empty: enter POP.
  - Otherwise, if move_valid and move_ready: latch move_dir and enter PUSH.
- PUSH: stk_push=1 and stk_push_val=latched dir; depth += 1. Next state GAP.
- GAP: stk_push=0. Next state IDLE. The gap guarantees a low cycle, because the stack detects rising edges.
- POP: stk_pop=1; depth -= 1. Next state WAIT.
- WAIT: stk_pop=0; capture stk_pop_val. Next state EMIT.
- EMIT: undo_valid=1 and undo_dir = captured XOR 2'b10. Next state:
  - POP, if rewind is active and depth != 0.
  - IDLE, otherwise. Rewind clears when it returns to IDLE.

Rules:
- move_ready = (state==IDLE) and en and !full and !undo_req and !rewind_req.
- Requests are never accepted when en is low. A sequence already in progress always completes regardless of en.
- undo_req or rewind_req while empty: ignored. No strobe is issued and no pulse is emitted.
- A move offered while full: move_ready stays low and the move is held off, not dropped.
- depth never wraps. PUSH occurs only when !full, and POP only when !empty.
- Reset state: state IDLE, depth 0, empty 1, full 0. All strobes, undo_valid, undo_dir, stk_push_val and rewind_busy are 0.

## Timing
- Move accepted in cycle T: stk_push is high in T+1 and low in T+2. depth updates at the end of T+1. move_ready returns in T+3 at the earliest.
- Undo accepted in cycle T: stk_pop is high in T+1, stk_pop_val is sampled in T+2, and undo_valid is high in T+3. The next acceptance can happen in T+4.
- Rewind: undo_valid pulses every 3 cycles until the stack is empty.
- All outputs are registered, except move_ready and stk_en, which are combinational from state, en and the request inputs.
- rst mid-sequence: the block returns to IDLE in the next cycle and the in-flight strobe drops. No undo_valid pulse is produced.

## Configuration
- PATH_RECORDER_REWIND_EN defined: rewind_req is honoured, and rewind_busy is high from POP entry until EMIT of the last entry.
- PATH_RECORDER_REWIND_EN undefined: rewind_req is ignored and rewind_busy is tied to 0. Both ports remain present, so the wrapper is unchanged.

## Structure
- The shared package holds:
  - the direction typedef (2-bit enum UP, RIGHT, DOWN, LEFT);
  - the inverse-direction function (XOR 2'b10);
  - the recorder state enum;
  - the default depth constant of 50.
- No sub-module is needed; this is a single FSM plus counter.

## Test plan
- Reset: assert rst for 2 cycles. Expect depth 0, empty 1, all strobes 0, and move_ready 1 in the cycle after release (with en=1).
- Push timing: offer move_dir=01 and accept it in cycle T. Expect stk_push=1 with stk_push_val=01 in T+1, stk_push=0 in T+2, depth=1, and move_ready high again in T+3.
- Undo: push 00 then 01, then assert undo_req. Expect a stk_pop pulse; the stack model returns 01, so undo_dir=11 and undo_valid is high for exactly one cycle. Expect depth=1.
- Empty and full bounds:
  - undo_req at depth 0: no stk_pop and no undo_valid.
  - With DEPTH=4: after 4 moves, full=1 and move_ready=0 while move_valid is held.
- Priority: in IDLE at depth 2, assert move_valid and undo_req in the same cycle. Expect the undo path to run with no stk_push, and the move to be accepted afterwards.
- Rewind, with PATH_RECORDER_REWIND_EN defined: at depth 3, pulse rewind_req. Expect 3 undo_valid pulses spaced 3 cycles apart, then depth 0 and rewind_busy 0. With the macro undefined, there are no pulses.

Source files
------------

// File: rtl/path_recorder_pkg.sv
// rtl/path_recorder_pkg.sv - shared types, constants and helpers for the path recorder
package path_recorder_pkg;

  localparam int DEFAULT_DEPTH = 50;

  typedef enum logic [1:0] {
    UP    = 2'b00,
    RIGHT = 2'b01,
    DOWN  = 2'b10,
    LEFT  = 2'b11
  } dir_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PUSH,
    ST_GAP,
    ST_POP,
    ST_WAIT,
    ST_EMIT
  } state_e;

  // Opposite directions differ only in the upper bit.
  function automatic dir_e inv_dir(input dir_e d);
    return dir_e'(d ^ 2'b10);
  endfunction

endpackage

// File: rtl/path_recorder.sv
// rtl/path_recorder.sv - move-history stack initiator: push strobes, undo/inverse-move, occupancy
// Optional rewind-all support is built when PATH_RECORDER_REWIND_EN is defined.
module path_recorder
  import path_recorder_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int DW    = 2,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          move_valid,
  input  logic [DW-1:0] move_dir,
  output logic          move_ready,
  input  logic          undo_req,
  output logic          undo_valid,
  output logic [DW-1:0] undo_dir,
  output logic [CW-1:0] depth,
  output logic          full,
  output logic          empty,
  input  logic          rewind_req,
  output logic          rewind_busy,
  output logic          stk_en,
  output logic          stk_push,
  output logic [DW-1:0] stk_push_val,
  output logic          stk_pop,
  input  logic [DW-1:0] stk_pop_val
);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  state_e        state_q, state_d;
  logic [CW-1:0] depth_q, depth_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          push_q, push_d;
  logic          pop_q, pop_d;
  logic          uv_q, uv_d;
  logic          rew_q, rew_d;
  logic [DW-1:0] pval_q, pval_d;
  logic [DW-1:0] udir_q, udir_d;

  logic rew_req_en;
  logic idle;
  logic rew_go;
  logic undo_go;
  logic move_go;

`ifdef PATH_RECORDER_REWIND_EN
  assign rew_req_en  = rewind_req;
  assign rewind_busy = rew_q;
`else
  logic unused_rewind;
  assign unused_rewind = rewind_req;
  assign rew_req_en    = 1'b0;
  assign rewind_busy   = 1'b0;
`endif

  assign idle       = (state_q == ST_IDLE);
  assign move_ready = idle & en & ~full_q & ~undo_req & ~rew_req_en;
  assign rew_go     = idle & en & rew_req_en & ~empty_q;
  assign undo_go    = idle & en & undo_req & ~empty_q & ~rew_go;
  assign move_go    = move_valid & move_ready;
  assign stk_en     = en | ~idle;

  always_comb begin
    state_d = state_q;
    depth_d = depth_q;
    pval_d  = pval_q;
    udir_d  = udir_q;
    rew_d   = rew_q;
    case (state_q)
      ST_IDLE: begin
        if (rew_go) begin
          state_d = ST_POP;
          rew_d   = 1'b1;
        end else if (undo_go) begin
          state_d = ST_POP;
        end else if (move_go) begin
          state_d = ST_PUSH;
          pval_d  = move_dir;
        end
      end
      ST_PUSH: begin
        depth_d = depth_q + CW'(1);
        state_d = ST_GAP;
      end
      // The stack is edge-triggered, so each strobe needs a low cycle after it.
      ST_GAP:  state_d = ST_IDLE;
      ST_POP: begin
        depth_d = depth_q - CW'(1);
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        udir_d  = DW'(inv_dir(dir_e'(stk_pop_val[1:0])));
        state_d = ST_EMIT;
      end
      ST_EMIT: begin
        if (rew_q && depth_q != '0) begin
          state_d = ST_POP;
        end else begin
          state_d = ST_IDLE;
          rew_d   = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Strobes and flags are registered decodes of the state being entered.
  always_comb begin
    push_d  = (state_d == ST_PUSH);
    pop_d   = (state_d == ST_POP);
    uv_d    = (state_d == ST_EMIT);
    full_d  = (depth_d == DEPTH_C);
    empty_d = (depth_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      depth_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      push_q  <= 1'b0;
      pop_q   <= 1'b0;
      uv_q    <= 1'b0;
      rew_q   <= 1'b0;
      pval_q  <= '0;
      udir_q  <= '0;
    end else begin
      state_q <= state_d;
      depth_q <= depth_d;
      full_q  <= full_d;
      empty_q <= empty_d;
      push_q  <= push_d;
      pop_q   <= pop_d;
      uv_q    <= uv_d;
      rew_q   <= rew_d;
      pval_q  <= pval_d;
      udir_q  <= udir_d;
    end
  end

  assign depth        = depth_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign stk_push     = push_q;
  assign stk_push_val = pval_q;
  assign stk_pop      = pop_q;
  assign undo_valid   = uv_q;
  assign undo_dir     = udir_q;

endmodule

// File: tb/tb_path_recorder.sv
// tb/tb_path_recorder.sv - randomized bench with a transaction-schedule reference model
module tb_path_recorder;

  localparam int DEPTH = 4;
  localparam int DW    = 2;
  localparam int CW    = $clog2(DEPTH + 1);
`ifdef PATH_RECORDER_REWIND_EN
  localparam bit REW = 1'b1;
`else
  localparam bit REW = 1'b0;
`endif

  logic          clk;
  logic          rst;
  logic          en;
  logic          move_valid;
  logic [DW-1:0] move_dir;
  logic          move_ready;
  logic          undo_req;
  logic          undo_valid;
  logic [DW-1:0] undo_dir;
  logic [CW-1:0] depth;
  logic          full;
  logic          empty;
  logic          rewind_req;
  logic          rewind_busy;
  logic          stk_en;
  logic          stk_push;
  logic [DW-1:0] stk_push_val;
  logic          stk_pop;
  logic [DW-1:0] stk_pop_val;

  path_recorder #(.DEPTH(DEPTH), .DW(DW)) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .move_valid   (move_valid),
    .move_dir     (move_dir),
    .move_ready   (move_ready),
    .undo_req     (undo_req),
    .undo_valid   (undo_valid),
    .undo_dir     (undo_dir),
    .depth        (depth),
    .full         (full),
    .empty        (empty),
    .rewind_req   (rewind_req),
    .rewind_busy  (rewind_busy),
    .stk_en       (stk_en),
    .stk_push     (stk_push),
    .stk_push_val (stk_push_val),
    .stk_pop      (stk_pop),
    .stk_pop_val  (stk_pop_val)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge-triggered stack with a registered pop output.
  logic [DW-1:0] env_q[$];
  logic          push_prev, pop_prev;
  always @(posedge clk) begin
    if (rst) begin
      env_q.delete();
      push_prev   <= 1'b0;
      pop_prev    <= 1'b0;
      stk_pop_val <= '0;
    end else begin
      push_prev <= stk_push;
      pop_prev  <= stk_pop;
      if (stk_push && !push_prev) env_q.push_back(stk_push_val);
      if (stk_pop && !pop_prev) stk_pop_val <= (env_q.size() > 0) ? env_q.pop_back() : '0;
    end
  end

  // Reference model: a move stack plus per-cycle schedules of expected events.
  int            checks, errors;
  int            cyc, idle_at, md;
  logic [DW-1:0] m_pv;
  logic [DW-1:0] mq[$];
  bit            e_push[int];
  bit            e_pop[int];
  bit            e_uv[int];
  bit            e_rb[int];
  logic [DW-1:0] e_ud[int];
  logic [DW-1:0] e_pv_at[int];
  int            e_depth_at[int];

  logic [31:0] s_depth, s_full, s_empty, s_push, s_pop, s_uv, s_ud, s_rb, s_mr, s_pv;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic sched_pops(input int n, input bit rw);
    for (int k = 0; k < n; k++) begin
      int t;
      t = cyc + 1 + 3 * k;
      e_pop[t]          = 1'b1;
      e_depth_at[t + 1] = md - 1 - k;
      e_uv[t + 2]       = 1'b1;
      e_ud[t + 2]       = mq.pop_back() ^ 2'b10;
      if (rw) begin
        e_rb[t] = 1'b1; e_rb[t + 1] = 1'b1; e_rb[t + 2] = 1'b1;
      end
    end
    idle_at = cyc + 1 + 3 * n;
  endtask

  task automatic step();
    bit idle, x_push, x_uv, x_mr;
    @(negedge clk);
    if (e_depth_at.exists(cyc)) md = e_depth_at[cyc];
    if (e_pv_at.exists(cyc)) m_pv = e_pv_at[cyc];
    idle   = (cyc >= idle_at);
    x_push = e_push.exists(cyc);
    x_uv   = e_uv.exists(cyc);
    x_mr   = idle && en && (md != DEPTH) && !undo_req && !(REW && rewind_req);
    chk("depth", 32'(depth), 32'(md));
    chk("full", 32'(full), 32'(md == DEPTH));
    chk("empty", 32'(empty), 32'(md == 0));
    chk("stk_push", 32'(stk_push), 32'(x_push));
    chk("stk_pop", 32'(stk_pop), 32'(e_pop.exists(cyc)));
    chk("undo_valid", 32'(undo_valid), 32'(x_uv));
    chk("rewind_busy", 32'(rewind_busy), 32'(e_rb.exists(cyc)));
    chk("move_ready", 32'(move_ready), 32'(x_mr));
    chk("stk_en", 32'(stk_en), 32'(en || !idle));
    if (x_push) chk("stk_push_val", 32'(stk_push_val), 32'(m_pv));
    if (x_uv) chk("undo_dir", 32'(undo_dir), 32'(e_ud[cyc]));
    s_depth = 32'(depth); s_full = 32'(full); s_empty = 32'(empty);
    s_push = 32'(stk_push); s_pop = 32'(stk_pop); s_uv = 32'(undo_valid);
    s_ud = 32'(undo_dir); s_rb = 32'(rewind_busy); s_mr = 32'(move_ready);
    s_pv = 32'(stk_push_val);
    if (rst) begin
      e_push.delete(); e_pop.delete(); e_uv.delete(); e_rb.delete(); e_ud.delete();
      e_pv_at.delete(); e_depth_at.delete();
      e_depth_at[cyc + 1] = 0;
      e_pv_at[cyc + 1]    = '0;
      mq.delete();
      idle_at = cyc + 1;
    end else if (idle && en) begin
      if (REW && rewind_req && md > 0) begin
        sched_pops(md, 1'b1);
      end else if (undo_req && md > 0) begin
        sched_pops(1, 1'b0);
      end else if (move_valid && x_mr) begin
        e_push[cyc + 1]     = 1'b1;
        e_pv_at[cyc + 1]    = move_dir;
        e_depth_at[cyc + 2] = md + 1;
        mq.push_back(move_dir);
        idle_at = cyc + 3;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    rst = 1'b1; step(); step(); rst = 1'b0;
  endtask

  task automatic do_move(input logic [DW-1:0] d);
    move_valid = 1'b1; move_dir = d; step(); move_valid = 1'b0; steps(2);
  endtask

  initial begin
    int pulses;
    checks = 0; errors = 0; cyc = 0; idle_at = 0; md = 0; m_pv = '0;
    rst = 1'b1; en = 1'b0; move_valid = 1'b0; move_dir = '0;
    undo_req = 1'b0; rewind_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0; en = 1'b1;

    step();
    chk("reset_depth", s_depth, 0);
    chk("reset_empty", s_empty, 1);
    chk("reset_full", s_full, 0);
    chk("reset_strobes", s_push | s_pop | s_uv | s_rb, 0);
    chk("reset_push_val", s_pv, 0);
    chk("reset_move_ready", s_mr, 1);

    move_valid = 1'b1; move_dir = 2'b01; step(); move_valid = 1'b0;
    step();
    chk("push_t1_strobe", s_push, 1);
    chk("push_t1_val", s_pv, 2'b01);
    step();
    chk("push_t2_strobe", s_push, 0);
    chk("push_t2_depth", s_depth, 1);
    step();
    chk("push_t3_ready", s_mr, 1);

    do_reset();
    do_move(2'b00); do_move(2'b01);
    undo_req = 1'b1; step(); undo_req = 1'b0;
    step();
    chk("undo_pop", s_pop, 1);
    step();
    step();
    chk("undo_valid_t3", s_uv, 1);
    chk("undo_dir_t3", s_ud, 2'b11);
    step();
    chk("undo_valid_t4", s_uv, 0);
    chk("undo_depth", s_depth, 1);

    do_reset();
    undo_req = 1'b1; steps(4); undo_req = 1'b0;
    chk("empty_undo_quiet", s_pop | s_uv, 0);

    do_move(2'b10); do_move(2'b11);
    move_valid = 1'b1; move_dir = 2'b00; undo_req = 1'b1; step(); undo_req = 1'b0;
    steps(3);
    chk("prio_no_push", s_push, 0);
    chk("prio_undo_dir", s_ud, 2'b01);
    step(); move_valid = 1'b0;
    step();
    chk("prio_move_after", s_push, 1);
    step();
    chk("prio_depth", s_depth, 2);

    do_reset();
    do_move(2'b00); do_move(2'b01); do_move(2'b10); do_move(2'b11);
    move_valid = 1'b1; move_dir = 2'b01; steps(4);
    chk("full_flag", s_full, 1);
    chk("full_ready", s_mr, 0);
    move_valid = 1'b0;

    do_reset();
    do_move(2'b00); do_move(2'b01); do_move(2'b11);
    pulses = 0;
    rewind_req = 1'b1; step(); rewind_req = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (s_uv[0]) pulses++;
    end
    chk("rewind_pulses", 32'(pulses), REW ? 3 : 0);
    chk("rewind_depth", s_depth, REW ? 0 : 3);
    chk("rewind_busy_end", s_rb, 0);

    do_reset();
    for (int i = 0; i < 2000; i++) begin
      rst        = ($urandom_range(0, 199) == 0);
      en         = ($urandom_range(0, 9) != 0);
      move_valid = $urandom_range(0, 1) == 1;
      move_dir   = DW'($urandom_range(0, 3));
      undo_req   = ($urandom_range(0, 99) < 15);
      rewind_req = ($urandom_range(0, 99) < 3);
      step();
    end
    rst = 1'b0; move_valid = 1'b0; undo_req = 1'b0; rewind_req = 1'b0;
    steps(20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
